// File: rtl/id_hazard_scoreboard.sv
// Decode-stage register scoreboard: per-register pending-write counters drive the ds_stall interlock.
// Optional write-back bypass of a retiring producer is enabled by defining SB_WB_BYPASS_EN.
module id_hazard_scoreboard #(
   parameter int CNT_W = 2,
   parameter int NREG  = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ds_valid,
   input  logic            ds_issue,
   input  logic            ds_gr_we,
   input  logic [4:0]      ds_dest,
   input  logic            ds_src1_en,
   input  logic [4:0]      ds_src1,
   input  logic            ds_src2_en,
   input  logic [4:0]      ds_src2,
   input  logic            ws_we,
   input  logic [4:0]      ws_waddr,
   output logic            ds_stall,
   output logic [NREG-1:0] pend_mask,
   output logic            src1_from_ws,
   output logic            src2_from_ws,
   output logic            sb_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt [NREG];
   logic             inc, dec, sat, hz1, hz2, byp1, byp2, underflow;
   logic [NREG-1:0]  inc_vec, dec_vec;

   assign dec = ws_we && (ws_waddr != 5'd0);
   assign sat = ds_valid && ds_gr_we && (ds_dest != 5'd0) && (cnt[ds_dest] == CNT_MAX);

`ifdef SB_WB_BYPASS_EN
   // A sole pending writer retiring this cycle can feed decode directly from write-back.
   assign byp1 = ds_valid && ds_src1_en && (ds_src1 != 5'd0) && dec
                 && (ws_waddr == ds_src1) && (cnt[ds_src1] == CNT_ONE);
   assign byp2 = ds_valid && ds_src2_en && (ds_src2 != 5'd0) && dec
                 && (ws_waddr == ds_src2) && (cnt[ds_src2] == CNT_ONE);
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   assign hz1 = ds_valid && ds_src1_en && (ds_src1 != 5'd0) && (cnt[ds_src1] != '0) && !byp1;
   assign hz2 = ds_valid && ds_src2_en && (ds_src2 != 5'd0) && (cnt[ds_src2] != '0) && !byp2;

   assign ds_stall     = hz1 || hz2 || sat;
   assign src1_from_ws = byp1;
   assign src2_from_ws = byp2;

   // Hazards look at pre-issue counts, so an instruction never stalls on its own dest.
   assign inc = ds_issue && !ds_stall && ds_gr_we && (ds_dest != 5'd0);

   assign underflow = dec && !(inc && (ds_dest == ws_waddr)) && (cnt[ws_waddr] == '0);

   always_comb begin
      inc_vec           = '0;
      dec_vec           = '0;
      pend_mask         = '0;
      inc_vec[ds_dest]  = inc;
      dec_vec[ws_waddr] = dec;
      for (int i = 1; i < NREG; i++) begin
         pend_mask[i] = (cnt[i] != '0);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            cnt[i] <= '0;
         end
         sb_err <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            case ({inc_vec[i], dec_vec[i]})
               2'b10:   if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_ONE;
               2'b01:   if (cnt[i] != '0)      cnt[i] <= cnt[i] - CNT_ONE;
               default: cnt[i] <= cnt[i];
            endcase
         end
         if (underflow) sb_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Scoreboard bench for id_hazard_scoreboard: directed plan plus random traffic against a pending-write model.
module tb_id_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ds_valid = 1'b0, ds_issue = 1'b0, ds_gr_we = 1'b0;
   logic [4:0]  ds_dest = '0, ds_src1 = '0, ds_src2 = '0, ws_waddr = '0;
   logic        ds_src1_en = 1'b0, ds_src2_en = 1'b0, ws_we = 1'b0;
   logic        ds_stall, src1_from_ws, src2_from_ws, sb_err;
   logic [31:0] pend_mask;

   typedef struct packed {
      logic        stall;
      logic [31:0] pend;
      logic        f1;
      logic        f2;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   pending[32];
   bit   err_m = 0;
   bit   byp_en;
   localparam int MAXC = 3;

   id_hazard_scoreboard #(.CNT_W(2), .NREG(32)) dut (
      .clk(clk), .reset(reset), .ds_valid(ds_valid), .ds_issue(ds_issue),
      .ds_gr_we(ds_gr_we), .ds_dest(ds_dest), .ds_src1_en(ds_src1_en),
      .ds_src1(ds_src1), .ds_src2_en(ds_src2_en), .ds_src2(ds_src2),
      .ws_we(ws_we), .ws_waddr(ws_waddr), .ds_stall(ds_stall),
      .pend_mask(pend_mask), .src1_from_ws(src1_from_ws),
      .src2_from_ws(src2_from_ws), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   initial begin
`ifdef SB_WB_BYPASS_EN
      byp_en = 1'b1;
`else
      byp_en = 1'b0;
`endif
   end

   // A read may skip the stall only when its single outstanding writer retires right now.
   function automatic bit bypass(input bit en, input int src);
      return byp_en && ds_valid && en && src != 0 && pending[src] == 1
             && ws_we && int'(ws_waddr) == src;
   endfunction

   function automatic bit hazard(input bit en, input int src);
      return ds_valid && en && src != 0 && pending[src] > 0 && !bypass(en, src);
   endfunction

   task automatic model_step();
      exp_t e;
      bit   issue_ok, retire;
      int   d, w;
      d = int'(ds_dest);
      w = int'(ws_waddr);
      e.f1    = bypass(ds_src1_en, int'(ds_src1));
      e.f2    = bypass(ds_src2_en, int'(ds_src2));
      e.stall = hazard(ds_src1_en, int'(ds_src1)) || hazard(ds_src2_en, int'(ds_src2))
                || (ds_valid && ds_gr_we && d != 0 && pending[d] == MAXC);
      e.err   = err_m;
      e.pend  = '0;
      for (int i = 1; i < 32; i++) e.pend[i] = (pending[i] != 0);
      exp_q.push_back(e);
      issue_ok = ds_issue && !e.stall && ds_gr_we && d != 0;
      retire   = ws_we && w != 0;
      if (!(issue_ok && retire && d == w)) begin
         if (issue_ok && pending[d] < MAXC) pending[d]++;
         if (retire) begin
            if (pending[w] == 0) err_m = 1;
            else pending[w]--;
         end
      end
   endtask

   task automatic cyc(input bit v, input bit iss, input bit gwe, input int dest,
                      input bit e1, input int s1, input bit e2, input int s2,
                      input bit wwe, input int wa);
      @(posedge clk);
      #1;
      reset = 1'b0;
      ds_valid = v; ds_issue = iss; ds_gr_we = gwe; ds_dest = 5'(dest);
      ds_src1_en = e1; ds_src1 = 5'(s1); ds_src2_en = e2; ds_src2 = 5'(s2);
      ws_we = wwe; ws_waddr = 5'(wa);
      model_step();
   endtask

   // Reset lands between edges; the monitor samples before any further edge, so state must clear asynchronously.
   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      ds_valid = 0; ds_issue = 0; ds_gr_we = 0; ds_src1_en = 0; ds_src2_en = 0; ws_we = 0;
      for (int i = 0; i < 32; i++) pending[i] = 0;
      err_m = 0;
      exp_q.push_back('0);
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         cmp("ds_stall", 32'(ds_stall), 32'(e.stall));
         cmp("pend_mask", pend_mask, e.pend);
         cmp("src1_from_ws", 32'(src1_from_ws), 32'(e.f1));
         cmp("src2_from_ws", 32'(src2_from_ws), 32'(e.f2));
         cmp("sb_err", 32'(sb_err), 32'(e.err));
      end
   end

   initial begin
      do_reset();
      // no prior issue: read r5 is clean
      cyc(1, 0, 0, 0, 1, 5, 0, 0, 0, 0);
      // RAW on r4, then retire it
      cyc(1, 1, 1, 4, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 4, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 4, 1, 4, 1, 4);
      cyc(1, 0, 0, 0, 1, 4, 0, 0, 0, 0);
      // saturate r7, issue blocked, then drain
      repeat (3) cyc(1, 1, 1, 7, 0, 0, 0, 0, 0, 0);
      repeat (2) cyc(1, 1, 1, 7, 1, 3, 0, 0, 0, 0);
      cyc(1, 1, 1, 7, 0, 0, 0, 0, 1, 7);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
      // simultaneous issue and retire of r9
      cyc(1, 1, 1, 9, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 1, 9, 0, 0, 0, 0, 1, 9);
      cyc(1, 0, 0, 0, 0, 0, 1, 9, 1, 9);
      // own dest as source does not self-stall
      cyc(1, 1, 1, 6, 1, 6, 1, 6, 0, 0);
      cyc(1, 0, 0, 0, 1, 6, 0, 0, 1, 6);
      // underflow on r12 is sticky
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 12);
      repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 1, 10, 0, 0, 0, 0, 0, 0);
      do_reset();
      // r0 is never tracked
      cyc(1, 1, 1, 0, 1, 0, 1, 0, 0, 0);
      cyc(1, 1, 1, 0, 1, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 79) == 0) begin
            do_reset();
         end else begin
            bit v;
            v = ($urandom_range(0, 3) != 0);
            cyc(v, v && $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 2) == 0, $urandom_range(0, 7));
         end
      end

      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d required=0 entries left", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
Scoreboard interlock controller for the decode stage of the in-order 5-stage pipeline. It tracks, per architectural register, how many issued instructions still have an outstanding write. It produces the decode stage's ready-go stall whenever a source operand read in decode has a pending writer. The decode stage drives its ready-go as !ds_stall; the scoreboard is updated on issue from decode and on register-file write back from the write-back stage.

Parameters:
CNT_W, 2, width of each per-register pending-write counter; max count = 2^CNT_W - 1
NREG, 32, number of architectural registers; register 0 is never tracked

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
ds_valid  input  1  decode stage holds a valid instruction
ds_issue  input  1  decode hands off to execute this cycle (ds_to_es_valid && es_allowin)
ds_gr_we  input  1  decoded instruction writes a GPR
ds_dest  input  5  decoded destination register (already r1 for bl)
ds_src1_en  input  1  decode reads src1 (rj)
ds_src1  input  5  src1 register number
ds_src2_en  input  1  decode reads src2 (rk or rd)
ds_src2  input  5  src2 register number
ws_we  input  1  write-back register-file write enable
ws_waddr  input  5  write-back destination register
ds_stall  output  1  hazard present; decode must hold
pend_mask  output  32  bit i = 1 when counter i is non-zero; bit 0 is always 0
src1_from_ws  output  1  src1 must take write-back data this cycle (see Optional Feature)
src2_from_ws  output  1  src2 must take write-back data this cycle
sb_err  output  1  sticky error flag

Behaviour:
- Reset (asynchronous, active-high): all counters = 0, sb_err = 0, therefore ds_stall = 0, pend_mask = 0, src*_from_ws = 0. Reset asserted mid-operation discards all pending state immediately.
- Issue event inc = ds_issue && !ds_stall && ds_gr_we && ds_dest != 0.
  - ds_issue while ds_stall is high is ignored for scoreboard update.
- Retire event dec = ws_we && ws_waddr != 0.
- Counter update per register i, at the clock edge:
  - inc only on i: +1.
  - dec only on i: -1.
  - Both on i in the same cycle: unchanged.
  - dec on a counter at 0: counter stays 0 and sb_err is set; sb_err clears only on reset.
- Hazard per source: hz_n = ds_valid && ds_srcN_en && ds_srcN != 0 && cnt[ds_srcN] != 0.
- Saturation guard: sat = ds_valid && ds_gr_we && ds_dest != 0 && cnt[ds_dest] == max.
- ds_stall = hz1 || hz2 || sat. It is combinational from registered counters and current inputs (0-cycle latency). Counters update 1 cycle after the event.
- The same register on src1 and src2: the hazard is evaluated identically for both.
- A source equal to its own dest (e.g. add r4,r4,r5): hazard checked against pre-issue count only; the instruction's own issue never stalls itself.
- Retiring write in the same cycle as a read without the feature: the counter is still non-zero, so decode stalls 1 extra cycle. The regfile has no write-through.
- Counter width arithmetic: unsigned CNT_W bits, no wrap. The increment is blocked by sat; the decrement is blocked at 0.

Optional Feature:
Macro SB_WB_BYPASS_EN.
- Defined: hz_n is suppressed when cnt[ds_srcN] == 1 && dec && ws_waddr == ds_srcN. In that case src_n_from_ws = 1 (qualified by ds_valid && ds_srcN_en && ds_srcN != 0), and decode muxes rf_wdata into rj_value/rkd_value, so the stall penalty is removed.
- Not defined: src1_from_ws = src2_from_ws = 0 constant, and the stall rule applies unchanged.

Test Plan:
- Reset, then ds_valid=1 with src1=5, src1_en=1, no prior issue -> ds_stall=0, pend_mask=0.
- Issue ds_dest=4 (gr_we=1). Next cycle decode src1=4 -> ds_stall=1, pend_mask[4]=1. Then ws_we=1, waddr=4:
  - Without macro: stall that cycle, stall=0 the next cycle.
  - With macro: stall=0 and src1_from_ws=1 in the retire cycle.
- Three back-to-back issues to dest=7 -> cnt=3. A fourth decode with dest=7 -> ds_stall=1 (sat), and the count stays 3 until a ws write to r7.
- Issue dest=9 and ws write r9 in the same cycle with cnt[9]=1 -> cnt[9] stays 1, pend_mask[9]=1.
- ws_we=1, waddr=12 with cnt[12]=0 -> sb_err=1 and stays 1; the counter remains 0. Asserting reset mid-run -> all counters 0, sb_err=0, asynchronously.
- Dest=0 issue and src=0 read -> never stall, pend_mask[0]=0.
